iot_byte_feeder: RTL and testbench

//  Upstream feeder for the IoT data-filter core. It buffers whole 128-bit records

---
 rtl/iot_byte_feeder.sv | 164 ++++++++++++++++
 tb/tb_iot_byte_feeder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iot_byte_feeder.sv
// iot_byte_feeder: record FIFO plus byte serialiser feeding the IoT data-filter core.
// Each buffered {fn, 128-bit data} record is sent as 16 bytes, MSB byte first.
// A byte goes out only while the core is not busy.
// The record is then held until the core strobes iot_valid, and is popped at that point.
// Optional build macro IOT_FEEDER_STATS_EN adds two outputs:
//   rec_done   - counter of completed records
//   drop_pulse - strobe for records offered while the FIFO is full

module iot_byte_feeder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rec_valid,
  output logic             rec_ready,
  input  logic [127:0]     rec_data,
  input  logic [2:0]       rec_fn,
  input  logic             busy,
  input  logic             iot_valid,
  output logic             in_en,
  output logic [7:0]       iot_in,
  output logic [2:0]       fn_sel
`ifdef IOT_FEEDER_STATS_EN
  ,
  output logic [CNT_W-1:0] rec_done,
  output logic             drop_pulse
`endif
);

  // Address width and pointer width; the extra pointer bit is the wrap flag.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  // Record storage: {fn[2:0], data[127:0]}.
  logic [130:0]   r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [1:0]     r_state;
  logic [3:0]     r_idx;
  logic [2:0]     r_fn_sel;

  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  logic           w_in_en;
  logic [130:0]   w_head;
  logic [7:0]     w_bytes [16];
  logic [7:0]     w_byte;

  // Occupancy flags: same address with differing wrap bits means full.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // A push is admitted only on the advertised ready, so a same-cycle pop never frees room for it.
  assign w_push = rec_valid & ~w_full;
  // The head record leaves only when the core reports its result.
  assign w_pop  = (r_state == S_WAIT) & iot_valid;

  // The head record is read combinationally, so the byte is valid in the same cycle as in_en.
  assign w_head = r_mem[r_rd_ptr[AW-1:0]];

  // Split the head payload into bytes; byte 0 is the most significant one.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_byte
      assign w_bytes[gi] = w_head[127-8*gi -: 8];
    end
  endgenerate

  assign w_byte = w_bytes[r_idx];

  // Offer a byte whenever we are streaming and the core can take it.
  assign w_in_en   = (r_state == S_SEND) & ~busy;
  assign in_en     = w_in_en;
  assign iot_in    = w_in_en ? w_byte : 8'h00;
  assign fn_sel    = r_fn_sel;
  assign rec_ready = ~w_full;

  // Record storage write; the contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {rec_fn, rec_data};
    end
  end

  // Write and read pointers advance on push and pop respectively.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  // Sequencer: pick up the head record, stream its 16 bytes, then wait for the core's result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_idx    <= 4'd0;
      r_fn_sel <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_state  <= S_SEND;
            r_idx    <= 4'd0;
            r_fn_sel <= w_head[130:128];
          end
        end
        S_SEND: begin
          if (w_in_en) begin
            if (r_idx == 4'd15) begin
              r_idx   <= 4'd0;
              r_state <= S_WAIT;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        S_WAIT: begin
          if (iot_valid) begin
            r_state  <= S_IDLE;
            r_fn_sel <= 3'd0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_idx    <= 4'd0;
          r_fn_sel <= 3'd0;
        end
      endcase
    end
  end

`ifdef IOT_FEEDER_STATS_EN
  logic [CNT_W-1:0] r_rec_done;

  // Count records the core has completed; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rec_done <= '0;
    end else if (w_pop) begin
      r_rec_done <= r_rec_done + CNT_W'(1);
    end
  end

  assign rec_done   = r_rec_done;
  assign drop_pulse = rec_valid & w_full;
`endif

endmodule

// File: tb/tb_iot_byte_feeder.sv
// Directed testbench for iot_byte_feeder (DEPTH=2).
// Checks reset, byte streaming, busy stall, full FIFO, ordering across pointer wrap, and ignored iot_valid.
// Stats outputs are checked only when the IOT_FEEDER_STATS_EN macro is defined.

`timescale 1ns/1ps

module tb_iot_byte_feeder;

  logic         clk;
  logic         rst;
  logic         rec_valid;
  logic         rec_ready;
  logic [127:0] rec_data;
  logic [2:0]   rec_fn;
  logic         busy;
  logic         iot_valid;
  logic         in_en;
  logic [7:0]   iot_in;
  logic [2:0]   fn_sel;
`ifdef IOT_FEEDER_STATS_EN
  logic [15:0]  rec_done;
  logic         drop_pulse;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int exp_done = 0;

  logic [127:0] tbl_data [6];
  logic [2:0]   tbl_fn   [6];

  iot_byte_feeder #(.DEPTH(2), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .rec_valid (rec_valid),
    .rec_ready (rec_ready),
    .rec_data  (rec_data),
    .rec_fn    (rec_fn),
    .busy      (busy),
    .iot_valid (iot_valid),
    .in_en     (in_en),
    .iot_in    (iot_in),
    .fn_sel    (fn_sel)
`ifdef IOT_FEEDER_STATS_EN
    ,
    .rec_done  (rec_done),
    .drop_pulse(drop_pulse)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [127:0] d, input logic [2:0] fn);
    rec_valid = 1'b1;
    rec_data  = d;
    rec_fn    = fn;
    step();
    rec_valid = 1'b0;
  endtask

  // Called in the SEND state.
  // Streams one record, optionally stalling before byte stall_at and asserting a spurious
  // iot_valid with byte spur_at; then completes the record with iot_valid.
  task automatic send_rec(input logic [127:0] d, input logic [2:0] fn,
                          input int stall_at, input int stall_len, input int spur_at);
    int k;
    int st;
    int cyc;
    logic [7:0] eb;
    k = 0;
    st = 0;
    cyc = 0;
    while (k < 16 && cyc < 64) begin
      if (k == stall_at && st < stall_len) begin
        busy = 1'b1;
        iot_valid = 1'b0;
        #1;
        chk("stall_in_en", in_en, 0);
        chk("stall_iot_in", iot_in, 0);
        st++;
      end else begin
        busy = 1'b0;
        iot_valid = (k == spur_at);
        eb = d[127-8*k -: 8];
        #1;
        chk("byte_in_en", in_en, 1);
        chk("byte_value", iot_in, eb);
        chk("send_fn_sel", fn_sel, fn);
        $display("byte %0d: iot_in=%02h fn_sel=%0d", k, iot_in, fn_sel);
        k++;
      end
      step();
      cyc++;
    end
    busy = 1'b0;
    iot_valid = 1'b0;
    chk("byte_count", k, 16);
    #1;
    chk("wait_in_en", in_en, 0);
    chk("wait_fn_sel", fn_sel, fn);
    iot_valid = 1'b1;
    step();
    iot_valid = 1'b0;
    exp_done++;
    #1;
    chk("idle_fn_sel", fn_sel, 0);
    chk("idle_in_en", in_en, 0);
  endtask

  // Called in an IDLE cycle with a record pending; checks the idle gap, then streams the record.
  task automatic run_rec(input logic [127:0] d, input logic [2:0] fn,
                         input int stall_at, input int stall_len, input int spur_at);
    #1;
    chk("pre_in_en", in_en, 0);
    chk("pre_fn_sel", fn_sel, 0);
    step();
    send_rec(d, fn, stall_at, stall_len, spur_at);
  endtask

  initial begin
    logic [127:0] ra;
    logic [127:0] rb;
    logic [127:0] rc;
    logic [7:0]   eb;

    ra = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    rb = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;
    rc = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    tbl_data[0] = 128'h10111213_14151617_18191A1B_1C1D1E1F;
    tbl_data[1] = 128'h20212223_24252627_28292A2B_2C2D2E2F;
    tbl_data[2] = 128'h30313233_34353637_38393A3B_3C3D3E3F;
    tbl_data[3] = 128'h40414243_44454647_48494A4B_4C4D4E4F;
    tbl_data[4] = 128'h50515253_54555657_58595A5B_5C5D5E5F;
    tbl_data[5] = 128'h60616263_64656667_68696A6B_6C6D6E6F;
    tbl_fn[0] = 3'd1; tbl_fn[1] = 3'd2; tbl_fn[2] = 3'd3;
    tbl_fn[3] = 3'd4; tbl_fn[4] = 3'd5; tbl_fn[5] = 3'd1;

    rst = 1'b0;
    rec_valid = 1'b0;
    rec_data = '0;
    rec_fn = '0;
    busy = 1'b0;
    iot_valid = 1'b0;
    #3;
    chk("rst_in_en", in_en, 0);
    chk("rst_iot_in", iot_in, 0);
    chk("rst_rec_ready", rec_ready, 1);
    chk("rst_fn_sel", fn_sel, 0);
    step();
    step();
    rst = 1'b1;
    step();

    // Reset while the seventh byte index is about to be offered.
    $display("test 1: reset mid-record");
    push(ra, 3'd3);
    step();
    for (int k = 0; k < 7; k++) begin
      step();
    end
    #1;
    chk("mid_in_en", in_en, 1);
    chk("mid_byte7", iot_in, 8'h77);
    rst = 1'b0;
    #1;
    chk("arst_in_en", in_en, 0);
    chk("arst_iot_in", iot_in, 0);
    chk("arst_rec_ready", rec_ready, 1);
    chk("arst_fn_sel", fn_sel, 0);
`ifdef IOT_FEEDER_STATS_EN
    chk("arst_rec_done", rec_done, 0);
`endif
    exp_done = 0;
    step();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      #1;
      chk("post_rst_in_en", in_en, 0);
    end

    $display("test 2: single record fn=3");
    push(ra, 3'd3);
    run_rec(ra, 3'd3, -1, 0, -1);
    chk("t2_rec_ready", rec_ready, 1);

    $display("test 3: busy stall after byte 4");
    push(ra, 3'd3);
    run_rec(ra, 3'd3, 5, 5, -1);

    $display("test 4: fill FIFO");
    push(ra, 3'd6);
    push(rb, 3'd2);
    rec_valid = 1'b1;
    rec_data = rc;
    rec_fn = 3'd7;
    for (int k = 0; k < 16; k++) begin
      eb = ra[127-8*k -: 8];
      #1;
      chk("full_rec_ready", rec_ready, 0);
`ifdef IOT_FEEDER_STATS_EN
      chk("full_drop_pulse", drop_pulse, 1);
`endif
      chk("full_in_en", in_en, 1);
      chk("full_byte", iot_in, eb);
      chk("full_fn_sel", fn_sel, 6);
      step();
    end
    #1;
    chk("full_wait_ready", rec_ready, 0);
    chk("full_wait_in_en", in_en, 0);
    iot_valid = 1'b1;
    step();
    iot_valid = 1'b0;
    exp_done++;
    #1;
    chk("pop_rec_ready", rec_ready, 1);
    chk("pop_in_en", in_en, 0);
    step();
    rec_valid = 1'b0;
    #1;
    chk("third_in_rec_ready", rec_ready, 0);
    send_rec(rb, 3'd2, -1, 0, -1);
    run_rec(rc, 3'd7, -1, 0, -1);
    chk("t4_rec_ready", rec_ready, 1);

    $display("test 5: order across wrap");
    for (int i = 0; i < 6; i++) begin
      push(tbl_data[i], tbl_fn[i]);
      run_rec(tbl_data[i], tbl_fn[i], -1, 0, -1);
    end
`ifdef IOT_FEEDER_STATS_EN
    chk("t5_rec_done", rec_done, 32'(exp_done));
`endif

    $display("test 6: spurious iot_valid");
    iot_valid = 1'b1;
    step();
    iot_valid = 1'b0;
    #1;
    chk("spur_idle_ready", rec_ready, 1);
    chk("spur_idle_in_en", in_en, 0);
    push(rb, 3'd5);
    iot_valid = 1'b1;
    #1;
    chk("spur_pend_in_en", in_en, 0);
    step();
    iot_valid = 1'b0;
    send_rec(rb, 3'd5, -1, 0, 3);
    for (int c = 0; c < 3; c++) begin
      step();
      #1;
      chk("spur_after_in_en", in_en, 0);
    end
`ifdef IOT_FEEDER_STATS_EN
    chk("t6_rec_done", rec_done, 32'(exp_done));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
